// File: rtl/ttest_prod_accum_if.sv
// Product-in / frame-sum-out stream bundle for ttest_prod_accum.
// master drives din/din_vld/dout_rdy; slave (the accumulator) drives din_rdy/dout/dout_vld.
interface ttest_prod_accum_if #(
  parameter int DIN_WIDTH = 46,
  parameter int ACC_WIDTH = 48
);
  logic [DIN_WIDTH-1:0] din;
  logic                 din_vld;
  logic                 din_rdy;
  logic [ACC_WIDTH-1:0] dout;
  logic                 dout_vld;
  logic                 dout_rdy;

  modport master (
    output din, din_vld, dout_rdy,
    input  din_rdy, dout, dout_vld
  );

  modport slave (
    input  din, din_vld, dout_rdy,
    output din_rdy, dout, dout_vld
  );
endinterface

// File: rtl/ttest_prod_accum.sv
// Registers and sums ACC_LEN multiplier products per frame; sum valid the edge after the last beat, din_rdy low while it waits.
// Overflow wraps by default; define TTEST_PROD_ACCUM_SAT_EN to clamp to all-ones instead (ovf sticky either way).
module ttest_prod_accum #(
  parameter int DIN_WIDTH = 46,
  parameter int ACC_LEN   = 4,
  parameter int ACC_WIDTH = 48,
  parameter int CNT_WIDTH = 2
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              clr,
  ttest_prod_accum_if.slave bus,
  output logic              ovf
);
  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  localparam int                   PAD  = ACC_WIDTH + 1 - DIN_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(ACC_LEN - 1);

  state_t               state;
  state_t               state_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] res;
  logic                 accept;
  logic                 last_beat;
  logic                 out_fire;

  assign accept    = bus.din_vld && bus.din_rdy;
  assign last_beat = (cnt == LAST);
  assign out_fire  = bus.dout_vld && bus.dout_rdy;
  assign sum       = {1'b0, acc} + {{PAD{1'b0}}, bus.din};

`ifdef TTEST_PROD_ACCUM_SAT_EN
  assign res = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
  assign res = sum[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ACC;
    end else begin
      case (state)
        ACC:     if (accept && last_beat) state_nxt = HOLD;
        HOLD:    if (out_fire)            state_nxt = ACC;
        default: state_nxt = ACC;
      endcase
    end
  end

  // Ready is a pure decode of the registered state, so dout_rdy never reaches din_rdy in the same cycle.
  always_comb begin
    bus.din_rdy = (state == ACC) && !ap_rst;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      bus.dout     <= '0;
      bus.dout_vld <= 1'b0;
    end else if (clr) begin
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      bus.dout_vld <= 1'b0;
    end else if (accept) begin
      if (sum[ACC_WIDTH]) ovf <= 1'b1;
      if (last_beat) begin
        bus.dout     <= res;
        bus.dout_vld <= 1'b1;
        acc          <= '0;
        cnt          <= '0;
      end else begin
        acc <= res;
        cnt <= cnt + 1'b1;
      end
    end else if (out_fire) begin
      bus.dout_vld <= 1'b0;
    end
  end
endmodule
